branch_unit: RTL

//  EX-stage branch resolution plus IF-stage dynamic prediction for the pipelined RV32I core.

---
 rtl/branch_unit_pkg.sv | 34 +++
 rtl/branch_unit_cmp.sv | 27 ++
 rtl/branch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/branch_unit_pkg.sv
// Shared branch-type encodings, BHT counter states and helpers for the branch unit.
package branch_unit_pkg;

  localparam int unsigned BR_TYPE_W = 3;

  // Branch-type encodings as carried down the pipeline; 3'd7 is undefined.
  typedef enum logic [BR_TYPE_W-1:0] {
    NOBRANCH = 3'd0,
    BEQ      = 3'd1,
    BNE      = 3'd2,
    BLT      = 3'd3,
    BLTU     = 3'd4,
    BGE      = 3'd5,
    BGEU     = 3'd6
  } br_type_e;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  localparam logic [1:0] BHT_STRONG_NT = 2'b00;
  localparam logic [1:0] BHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] BHT_WEAK_T    = 2'b10;
  localparam logic [1:0] BHT_STRONG_T  = 2'b11;

  // True for the six conditional branch encodings only.
  function automatic logic is_cond_br(input logic [BR_TYPE_W-1:0] br_type);
    logic cond;
    cond = 1'b0;
    case (br_type)
      BEQ, BNE, BLT, BLTU, BGE, BGEU: cond = 1'b1;
      default:                        cond = 1'b0;
    endcase
    return cond;
  endfunction

endpackage

// File: rtl/branch_unit_cmp.sv
// Combinational branch condition evaluation on forwarded rs1/rs2.
module branch_cmp
  import branch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0]      i_reg1,
  input  logic [XLEN-1:0]      i_reg2,
  input  logic [BR_TYPE_W-1:0] i_br_type,
  output logic                 o_br
);

  // Select the comparison for the branch type; non-branches and undefined codes never take.
  always_comb begin
    o_br = 1'b0;
    case (i_br_type)
      BEQ:     o_br = (i_reg1 == i_reg2);
      BNE:     o_br = (i_reg1 != i_reg2);
      BLT:     o_br = ($signed(i_reg1) <  $signed(i_reg2));
      BGE:     o_br = ($signed(i_reg1) >= $signed(i_reg2));
      BLTU:    o_br = (i_reg1 <  i_reg2);
      BGEU:    o_br = (i_reg1 >= i_reg2);
      default: o_br = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// EX-stage branch resolution with an IF-stage direct-mapped BHT/BTB predictor
// and saturating performance counters.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned PERF_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [XLEN-1:0]      if_pc,
  output logic                 if_pred_taken,
  output logic [XLEN-1:0]      if_pred_target,
  input  logic                 ex_valid,
  input  logic                 ex_stall,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [BR_TYPE_W-1:0] ex_br_type,
  input  logic [XLEN-1:0]      ex_reg1,
  input  logic [XLEN-1:0]      ex_reg2,
  input  logic [XLEN-1:0]      ex_target,
  input  logic                 ex_pred_taken,
  input  logic [XLEN-1:0]      ex_pred_target,
  output logic                 br,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [PERF_W-1:0]    perf_branches,
  output logic [PERF_W-1:0]    perf_mispred
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic              r_valid  [DEPTH];
  logic [TAG_W-1:0]  r_tag    [DEPTH];
  logic [XLEN-1:0]   r_target [DEPTH];
  logic [1:0]        r_cnt    [DEPTH];
  logic [PERF_W-1:0] r_perf_branches;
  logic [PERF_W-1:0] r_perf_mispred;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic [TAG_W-1:0]  w_if_tag;
  logic [TAG_W-1:0]  w_ex_tag;
  logic              w_if_hit;
  logic              w_ex_hit;
  logic              w_cmp_br;
  logic              w_upd_cond;
  logic              w_upd_inval;
  logic [1:0]        w_cnt_next;
  logic              w_unused_pc_lsb;

  assign w_if_idx = if_pc[IDX_W+1:2];
  assign w_if_tag = if_pc[XLEN-1:IDX_W+2];
  assign w_ex_idx = ex_pc[IDX_W+1:2];
  assign w_ex_tag = ex_pc[XLEN-1:IDX_W+2];
  assign w_unused_pc_lsb = ^if_pc[1:0];

  assign perf_branches = r_perf_branches;
  assign perf_mispred  = r_perf_mispred;

  branch_cmp #(
    .XLEN(XLEN)
  ) u_branch_cmp (
    .i_reg1   (ex_reg1),
    .i_reg2   (ex_reg2),
    .i_br_type(ex_br_type),
    .o_br     (w_cmp_br)
  );

  // IF lookup: predict taken on a valid, tag-matching entry with counter MSB set.
  always_comb begin
    w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    if_pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
    if_pred_target = '0;
    if (if_pred_taken) begin
      if_pred_target = r_target[w_if_idx];
    end
  end

  // EX resolve: actual direction, mispredict detection, redirect target and update enables.
  always_comb begin
    br          = 1'b0;
    mispredict  = 1'b0;
    redirect_pc = '0;
    w_upd_cond  = 1'b0;
    w_upd_inval = 1'b0;
    if (ex_valid && !ex_stall) begin
      br          = w_cmp_br;
      redirect_pc = w_cmp_br ? ex_target : ex_pc + XLEN'(4);
      if (is_cond_br(ex_br_type)) begin
        w_upd_cond = 1'b1;
        mispredict = (w_cmp_br != ex_pred_taken) ||
                     (w_cmp_br && (ex_pred_target != ex_target));
      end else if ((ex_br_type == NOBRANCH) && ex_pred_taken) begin
        // A non-branch predicted taken means the BTB aliased onto it.
        w_upd_inval = 1'b1;
        mispredict  = 1'b1;
      end
    end
  end

  // Saturating counter step for the EX entry.
  always_comb begin
    w_ex_hit   = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    w_cnt_next = r_cnt[w_ex_idx];
    if (w_cmp_br) begin
      if (r_cnt[w_ex_idx] != BHT_STRONG_T) begin
        w_cnt_next = r_cnt[w_ex_idx] + 2'd1;
      end
    end else if (r_cnt[w_ex_idx] != BHT_STRONG_NT) begin
      w_cnt_next = r_cnt[w_ex_idx] - 2'd1;
    end
  end

  // Table update from EX: train on hit, install on miss, drop aliased entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= BHT_WEAK_NT;
      end
    end else if (w_upd_cond) begin
      r_target[w_ex_idx] <= ex_target;
      if (w_ex_hit) begin
        r_cnt[w_ex_idx] <= w_cnt_next;
      end else begin
        r_valid[w_ex_idx] <= 1'b1;
        r_tag[w_ex_idx]   <= w_ex_tag;
        r_cnt[w_ex_idx]   <= w_cmp_br ? BHT_WEAK_T : BHT_WEAK_NT;
      end
    end else if (w_upd_inval) begin
      r_valid[w_ex_idx] <= 1'b0;
    end
  end

  // Performance counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (w_upd_cond && (r_perf_branches != '1)) begin
        r_perf_branches <= r_perf_branches + PERF_W'(1);
      end
      if (mispredict && (r_perf_mispred != '1)) begin
        r_perf_mispred <= r_perf_mispred + PERF_W'(1);
      end
    end
  end

endmodule
